// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP adder result buffer.
// NaN canonicalization helper is used only when FP_RESULT_NAN_CANON_EN is defined.
package fp_add_pkg;
  localparam logic [31:0] FP_CANON_QNAN = 32'h7fc00000;
  localparam logic [7:0]  FP_EXP_MAX    = 8'hFF;

  typedef struct packed {
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
  } fp_add_result_t;

  // Any NaN (max exponent, nonzero mantissa) collapses to the canonical quiet NaN.
  function automatic logic [31:0] fp_canon_nan(input logic [31:0] v);
    return (v[30:23] == FP_EXP_MAX && v[22:0] != 23'd0) ? FP_CANON_QNAN : v;
  endfunction
endpackage

// File: rtl/fp_result_fifo.sv
// Generic DEPTH-entry FIFO with occupancy count and synchronous flush.
// Storage is never cleared; the read port reads as zero while empty.
module fp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fp_add_result_buffer.sv
// Result FIFO behind the FP adder with valid/ready writeback and sticky OF/UF flags.
// Define FP_RESULT_NAN_CANON_EN to canonicalize NaN results on capture.
module fp_add_result_buffer
  import fp_add_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  output logic             sticky_of,
  output logic             sticky_uf,
  input  logic             sticky_clr,
  output logic [CW-1:0]    count
);
  localparam int EW = $bits(fp_add_result_t) + TAG_W;

  fp_add_result_t     ent_in, ent_out;
  logic [EW-1:0]      wdata, rdata;
  logic               push, pop, full, empty;

  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef FP_RESULT_NAN_CANON_EN
  assign ent_in.result = fp_canon_nan(in_result);
`else
  assign ent_in.result = in_result;
`endif
  assign ent_in.overflow  = in_overflow;
  assign ent_in.underflow = in_underflow;
  assign wdata            = {in_tag, ent_in};

  fp_result_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign {out_tag, ent_out} = rdata;
  assign out_result         = ent_out.result;
  assign out_overflow       = ent_out.overflow;
  assign out_underflow      = ent_out.underflow;

  // Flags accumulate on retirement; a flagged pop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_of <= 1'b0;
      sticky_uf <= 1'b0;
    end else begin
      sticky_of <= (sticky_of & ~sticky_clr) | (pop & out_overflow);
      sticky_uf <= (sticky_uf & ~sticky_clr) | (pop & out_underflow);
    end
  end
endmodule
